// File: rtl/seq_gen_pkg.sv
// Shared constants, index type and code decode for the cyclic sequence generator.
// Codes cycle 000 -> 010 -> 011 -> 101 and back to 000.
package seq_gen_pkg;

  localparam int SEQ_W = 3;

  localparam logic [SEQ_W-1:0] SEQ0 = 3'b000;
  localparam logic [SEQ_W-1:0] SEQ1 = 3'b010;
  localparam logic [SEQ_W-1:0] SEQ2 = 3'b011;
  localparam logic [SEQ_W-1:0] SEQ3 = 3'b101;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } idx_t;

  function automatic logic [SEQ_W-1:0] code_of(idx_t i);
    logic [SEQ_W-1:0] c;
    c = SEQ0;
    case (i)
      S0: c = SEQ0;
      S1: c = SEQ1;
      S2: c = SEQ2;
      S3: c = SEQ3;
      default: c = SEQ0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_gen_ctr.sv
// Modulo-4 index counter with async active-high reset and sync clear.
// Ports: clk, rst (async, high), clr (sync to 0), idx (2-bit index).
module seq_gen_ctr
  import seq_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic [1:0] idx
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (clr) begin
      idx <= 2'd0;
    end else begin
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/test.sv
// Free-running 4-state code generator: out cycles 000,010,011,101.
// Ports: clk, rst (async, high), out (3-bit registered code).
module test
  import seq_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [SEQ_W-1:0] out
);

  logic [1:0] idx;
  logic [1:0] idx_nxt;
  logic       bad;

  assign idx_nxt = idx + 2'd1;

  // out must always equal the decode of idx; any disagreement
  // (e.g. an upset code) resyncs both registers to the first code.
  assign bad = (out != code_of(idx_t'(idx)));

  seq_gen_ctr u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (bad),
    .idx (idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= SEQ0;
    end else if (bad) begin
      out <= SEQ0;
    end else begin
      out <= code_of(idx_t'(idx_nxt));
    end
  end

endmodule

// File: tb/tb_test.sv
// Self-checking bench for the cyclic code generator.
// Reference model: position in a 4-entry code table.
module tb_test;

  logic       clk;
  logic       rst;
  logic [2:0] out;

  int checks;
  int errors;
  int pos;
  int prev;

  logic [2:0] tbl [4];

  test dut (
    .clk (clk),
    .rst (rst),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [2:0] obs,
                       input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge; model advances unless reset is held.
  task automatic step(input string tag);
    @(posedge clk);
    prev = pos;
    if (!rst) pos = (pos + 1) % 4;
    #1;
    check(tag, out, tbl[pos]);
  endtask

  initial begin
    tbl[0] = 3'b000;
    tbl[1] = 3'b010;
    tbl[2] = 3'b011;
    tbl[3] = 3'b101;
    checks = 0;
    errors = 0;
    pos = 0;
    prev = 0;

    rst = 1'b1;
    #2;
    check("reset_async_start", out, 3'b000);
    for (int i = 0; i < 3; i++) step("reset_hold");

    @(negedge clk);
    rst = 1'b0;
    step("first_after_release");
    check("latency_010", out, 3'b010);
    for (int i = 0; i < 7; i++) begin
      step("run8");
      if (tbl[prev] == 3'b101) check("wrap_101_000", out, 3'b000);
    end

    for (int i = 0; i < 5; i++) step("run5");

    for (int i = 0; i < 8 && pos != 2; i++) step("seek_011");
    check("at_011", out, 3'b011);
    #2;
    rst = 1'b1;
    pos = 0;
    #1;
    check("async_rst_mid", out, 3'b000);
    step("mid_rst_hold");
    @(negedge clk);
    rst = 1'b0;
    step("after_mid_rst");
    check("after_mid_rst_010", out, 3'b010);

    step("pre_coincident");
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    @(posedge clk);
    rst <= 1'b0;
    #1;
    check("coincident_edge", out, 3'b000);
    step("coincident_next");
    check("coincident_next_010", out, 3'b010);

    step("pre_force");
    @(negedge clk);
    force dut.out = 3'b111;
    #1;
    release dut.out;
    #1;
    check("forced_111", out, 3'b111);
    @(posedge clk);
    pos = 0;
    #1;
    check("recover_000", out, 3'b000);
    step("recover_010");
    step("recover_011");
    step("recover_101");
    step("recover_wrap");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        pos = 0;
        #1;
        check("rand_async_rst", out, 3'b000);
        if ($urandom_range(0, 1) == 1) step("rand_rst_hold");
        @(negedge clk);
        rst = 1'b0;
      end else begin
        step("rand_run");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
